// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: ALU execution stage behind the reservation station.
// One operation is captured per cycle into S1. Its result is computed
// combinationally from S1 and pushed into a small result FIFO on the next
// edge. The FIFO head is offered on the result broadcast bus and is removed
// when the bus is granted.
module alu_cdb_unit #(
    parameter int ROB_SZ_LOG = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [31:0]           in_Vj,
    input  logic [31:0]           in_Vk,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_pc,
    input  logic [3:0]            in_opcode,
    input  logic [3:0]            in_optype,
    input  logic [ROB_SZ_LOG:0]   in_dest,
    input  logic                  cdb_grant,
    output logic                  almost_full,
    output logic                  out_valid,
    output logic [ROB_SZ_LOG:0]   out_dest,
    output logic [31:0]           out_res,
    output logic                  out_br_flg,
    output logic                  out_br_taken,
    output logic [31:0]           out_br_target
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ROB_SZ_LOG + 1;

    localparam logic [3:0] OT_R      = 4'd0;
    localparam logic [3:0] OT_I      = 4'd1;
    localparam logic [3:0] OT_BRANCH = 4'd2;
    localparam logic [3:0] OT_LUI    = 4'd3;
    localparam logic [3:0] OT_AUIPC  = 4'd4;
    localparam logic [3:0] OT_JAL    = 4'd5;
    localparam logic [3:0] OT_JALR   = 4'd6;

    // S1 operation register
    logic          r_s1_valid;
    logic [31:0]   r_vj, r_vk, r_imm, r_pc;
    logic [3:0]    r_opcode, r_optype;
    logic [TW-1:0] r_dest;

    // Result FIFO storage and bookkeeping
    logic [TW-1:0] r_mem_dest   [FIFO_DEPTH];
    logic [31:0]   r_mem_res    [FIFO_DEPTH];
    logic          r_mem_flg    [FIFO_DEPTH];
    logic          r_mem_taken  [FIFO_DEPTH];
    logic [31:0]   r_mem_target [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;

    // Combinational result of the S1 operation
    logic [31:0] w_op2;
    logic [4:0]  w_shamt;
    logic [31:0] w_res;
    logic        w_br_flg;
    logic        w_br_taken;
    logic [31:0] w_br_target;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_advance;
    logic [CW:0]   w_occ;

    assign w_op2   = (r_optype == OT_R) ? r_vk : r_imm;
    assign w_shamt = w_op2[4:0];

    // Integer result, branch compare and target resolution for the S1 entry
    always_comb begin
        w_res       = '0;
        w_br_flg    = 1'b0;
        w_br_taken  = 1'b0;
        w_br_target = '0;
        case (r_optype)
            OT_R, OT_I: begin
                case (r_opcode)
                    4'd0: w_res = r_vj + w_op2;
                    4'd1: w_res = (r_optype == OT_R) ? (r_vj - w_op2) : (r_vj + w_op2);
                    4'd2: w_res = r_vj << w_shamt;
                    4'd3: w_res = {31'b0, $signed(r_vj) < $signed(w_op2)};
                    4'd4: w_res = {31'b0, r_vj < w_op2};
                    4'd5: w_res = r_vj ^ w_op2;
                    4'd6: w_res = r_vj >> w_shamt;
                    4'd7: w_res = $signed(r_vj) >>> w_shamt;
                    4'd8: w_res = r_vj | w_op2;
                    4'd9: w_res = r_vj & w_op2;
                    default: w_res = '0;
                endcase
            end
            OT_BRANCH: begin
                w_br_flg    = 1'b1;
                w_br_target = r_pc + r_imm;
                case (r_opcode)
                    4'd0: w_br_taken = (r_vj == r_vk);
                    4'd1: w_br_taken = (r_vj != r_vk);
                    4'd2: w_br_taken = ($signed(r_vj) <  $signed(r_vk));
                    4'd3: w_br_taken = ($signed(r_vj) >= $signed(r_vk));
                    4'd4: w_br_taken = (r_vj <  r_vk);
                    4'd5: w_br_taken = (r_vj >= r_vk);
                    default: w_br_taken = 1'b0;
                endcase
            end
            OT_LUI:   w_res = r_imm;
            OT_AUIPC: w_res = r_pc + r_imm;
            OT_JAL:   w_res = r_pc + 32'd4;
            OT_JALR: begin
                w_res       = r_pc + 32'd4;
                w_br_flg    = 1'b1;
                w_br_taken  = 1'b1;
                w_br_target = (r_vj + r_imm) & ~32'd1;
            end
            default: w_res = '0;
        endcase
    end

    // A full FIFO can still accept a push when its head leaves on the same edge
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && cdb_grant;
    assign w_push      = r_s1_valid && (!w_full || w_pop);
    assign w_advance   = !rst && rdy && !flush;
    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_s1_valid};
    assign almost_full = (w_occ >= (CW+1)'(FIFO_DEPTH - 1));

    // Head entry drives the bus; an empty FIFO shows all zeros
    assign out_dest      = out_valid ? r_mem_dest[r_rd_ptr]   : '0;
    assign out_res       = out_valid ? r_mem_res[r_rd_ptr]    : '0;
    assign out_br_flg    = out_valid ? r_mem_flg[r_rd_ptr]    : 1'b0;
    assign out_br_taken  = out_valid ? r_mem_taken[r_rd_ptr]  : 1'b0;
    assign out_br_target = out_valid ? r_mem_target[r_rd_ptr] : '0;

    // Control state: S1 valid, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_s1_valid <= in_valid;
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // S1 operand capture; payload needs no reset because S1 valid qualifies it
    always_ff @(posedge clk) begin
        if (w_advance && in_valid) begin
            r_vj     <= in_Vj;
            r_vk     <= in_Vk;
            r_imm    <= in_imm;
            r_pc     <= in_pc;
            r_opcode <= in_opcode;
            r_optype <= in_optype;
            r_dest   <= in_dest;
        end
    end

    // FIFO write of the computed S1 result
    always_ff @(posedge clk) begin
        if (w_advance && w_push) begin
            r_mem_dest[r_wr_ptr]   <= r_dest;
            r_mem_res[r_wr_ptr]    <= w_res;
            r_mem_flg[r_wr_ptr]    <= w_br_flg;
            r_mem_taken[r_wr_ptr]  <= w_br_taken;
            r_mem_target[r_wr_ptr] <= w_br_target;
        end
    end

    // Flag an upstream that ignored almost_full and lost a result
    always_ff @(posedge clk) begin
        if (w_advance)
            assert (!(r_s1_valid && w_full && !w_pop))
                else $error("alu_cdb_unit: result dropped, push into full FIFO");
    end
endmodule

// File: tb/tb_alu_cdb_unit.sv
// tb_alu_cdb_unit: directed and random stimulus against a queue-based model
// of the execution unit; outputs are compared on every falling clock edge.
module tb_alu_cdb_unit;
    localparam int RL = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, flush, in_valid, cdb_grant;
    logic [31:0]   in_Vj, in_Vk, in_imm, in_pc;
    logic [3:0]    in_opcode, in_optype;
    logic [RL:0]   in_dest;
    logic          almost_full, out_valid, out_br_flg, out_br_taken;
    logic [RL:0]   out_dest;
    logic [31:0]   out_res, out_br_target;

    int n_err = 0;
    int n_chk = 0;

    alu_cdb_unit #(.ROB_SZ_LOG(RL), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_optype(in_optype),
        .in_dest(in_dest), .cdb_grant(cdb_grant),
        .almost_full(almost_full), .out_valid(out_valid), .out_dest(out_dest),
        .out_res(out_res), .out_br_flg(out_br_flg), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RL:0]  dest;
        logic [31:0]  res;
        bit           flg;
        bit           taken;
        logic [31:0]  target;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    bit   pend_v = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of one operation, straight from the instruction semantics
    function automatic ent_t compute(input logic [3:0] ot, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] vk,
                                     input logic [31:0] imm, input logic [31:0] pc,
                                     input logic [RL:0] dest);
        ent_t e;
        logic [31:0] b;
        int sh;
        int sa, sb;
        e.dest = dest; e.res = 0; e.flg = 0; e.taken = 0; e.target = 0;
        b  = (ot == 0) ? vk : imm;
        sh = int'(b % 32);
        sa = int'(a);
        sb = (ot == 2) ? int'(vk) : int'(b);
        if (ot == 0 || ot == 1) begin
            if      (op == 0 || (op == 1 && ot == 1)) e.res = a + b;
            else if (op == 1) e.res = a - b;
            else if (op == 2) e.res = a << sh;
            else if (op == 3) e.res = (sa < sb) ? 1 : 0;
            else if (op == 4) e.res = (a < b) ? 1 : 0;
            else if (op == 5) e.res = a ^ b;
            else if (op == 6) e.res = a >> sh;
            else if (op == 7) e.res = 32'(sa >>> sh);
            else if (op == 8) e.res = a | b;
            else if (op == 9) e.res = a & b;
        end else if (ot == 2) begin
            e.flg = 1;
            e.target = pc + imm;
            if      (op == 0) e.taken = (a == vk);
            else if (op == 1) e.taken = (a != vk);
            else if (op == 2) e.taken = (sa < sb);
            else if (op == 3) e.taken = (sa >= sb);
            else if (op == 4) e.taken = (a < vk);
            else if (op == 5) e.taken = (a >= vk);
        end else if (ot == 3) e.res = imm;
        else if (ot == 4) e.res = pc + imm;
        else if (ot == 5) e.res = pc + 4;
        else if (ot == 6) begin
            e.res = pc + 4; e.flg = 1; e.taken = 1;
            e.target = (a + imm) & 32'hFFFF_FFFE;
        end
        return e;
    endfunction

    function automatic bit model_af();
        return (q.size() + int'(pend_v)) >= D - 1;
    endfunction

    // Model state advances on every rising edge from the same inputs the DUT sees
    always @(posedge clk) begin
        if (rst || (rdy && flush)) begin
            q.delete();
            pend_v = 0;
        end else if (rdy) begin
            if (q.size() != 0 && cdb_grant) void'(q.pop_front());
            if (pend_v && q.size() < D) q.push_back(pend);
            pend_v = in_valid;
            pend = compute(in_optype, in_opcode, in_Vj, in_Vk, in_imm, in_pc, in_dest);
        end
    end

    // Output comparison against the model, once per cycle
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("almost_full", 32'(almost_full), 32'(model_af()));
        if (q.size() != 0) begin
            check("out_dest", 32'(out_dest), 32'(q[0].dest));
            check("out_res", out_res, q[0].res);
            check("out_br_flg", 32'(out_br_flg), 32'(q[0].flg));
            if (q[0].flg) begin
                check("out_br_taken", 32'(out_br_taken), 32'(q[0].taken));
                check("out_br_target", out_br_target, q[0].target);
            end
        end else begin
            check("empty_dest", 32'(out_dest), 32'd0);
            check("empty_res", out_res, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] ot, input logic [3:0] op,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [RL:0] dest);
        in_valid = v; in_optype = ot; in_opcode = op; in_Vj = vj; in_Vk = vk;
        in_imm = imm; in_pc = pc; in_dest = dest;
        $display("issue v=%0d ot=%0d op=%0d vj=%h vk=%h imm=%h pc=%h dest=%0d",
                 v, ot, op, vj, vk, imm, pc, dest);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        ent_t e;
        int issued;
        rst = 1; rdy = 1; flush = 0; cdb_grant = 1;
        drive(1, 0, 0, 1, 1, 0, 0, 1);
        repeat (2) tick();
        rst = 0; idle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_res", out_res, 32'd0);

        // Model pins against hand-computed values
        e = compute(0, 1, 0, 1, 0, 0, 1);             check("pin_sub", e.res, 32'hFFFF_FFFF);
        e = compute(0, 7, 32'h8000_0000, 32'h21, 0, 0, 1); check("pin_sra", e.res, 32'hC000_0000);
        e = compute(1, 1, 10, 0, 3, 0, 1);            check("pin_subi", e.res, 32'd13);
        e = compute(2, 2, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 1);
        check("pin_blt", {30'd0, e.flg, e.taken}, 32'd3);
        check("pin_blt_tgt", e.target, 32'hF8);

        // ADD chain
        drive(1, 0, 0, 5, 7, 0, 0, 3); tick(); idle();
        check("add_lat", 32'(out_valid), 32'd0);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_dest", 32'(out_dest), 32'd3);
        check("add_res", out_res, 32'd12);
        tick();
        check("add_popped", 32'(out_valid), 32'd0);

        // ALU edge cases, one per cycle
        drive(1, 0, 1, 0, 1, 0, 0, 1);                       tick();
        drive(1, 0, 7, 32'h8000_0000, 32'h21, 0, 0, 2);      tick();
        check("sub_res", out_res, 32'hFFFF_FFFF);
        drive(1, 0, 4, 1, 32'hFFFF_FFFF, 0, 0, 3);           tick();
        check("sra_res", out_res, 32'hC000_0000);
        drive(1, 0, 3, 1, 32'hFFFF_FFFF, 0, 0, 4);           tick();
        check("sltu_res", out_res, 32'd1);
        idle(); tick();
        check("slt_res", out_res, 32'd0);
        tick();

        // Branch and JALR resolution
        drive(1, 2, 2, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 5); tick();
        drive(1, 6, 0, 32'h1001, 0, 2, 32'h40, 6); tick(); idle();
        check("blt_flg", 32'(out_br_flg), 32'd1);
        check("blt_taken", 32'(out_br_taken), 32'd1);
        check("blt_target", out_br_target, 32'hF8);
        tick();
        check("jalr_res", out_res, 32'h44);
        check("jalr_target", out_br_target, 32'h1002);
        check("jalr_taken", 32'(out_br_taken), 32'd1);
        tick();

        // Backpressure: no grant, issue until almost_full
        cdb_grant = 0; issued = 0;
        for (int i = 0; i < 8; i++) begin
            if (!almost_full) begin
                drive(1, 0, 0, 32'(i), 32'd100, 0, 0, 4'(i + 1)); issued++;
            end else idle();
            tick();
        end
        idle();
        check("bp_issued", 32'(issued), 32'd3);
        cdb_grant = 1;
        repeat (5) tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush with S1 valid and two FIFO entries
        cdb_grant = 0;
        drive(1, 0, 0, 1, 1, 0, 0, 1); tick();
        drive(1, 0, 0, 2, 2, 0, 0, 2); tick();
        drive(1, 0, 0, 3, 3, 0, 0, 3); tick();
        check("pre_flush_valid", 32'(out_valid), 32'd1);
        drive(1, 0, 0, 4, 4, 0, 0, 4); flush = 1; tick();
        flush = 0; idle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_af", 32'(almost_full), 32'd0);
        cdb_grant = 1;
        drive(1, 0, 0, 1, 2, 0, 0, 5); tick(); idle(); tick();
        check("post_flush_dest", 32'(out_dest), 32'd5);
        check("post_flush_res", out_res, 32'd3);
        tick();

        // Pause with a result at the head and grant held
        drive(1, 0, 0, 10, 20, 0, 0, 7); tick(); idle(); tick();
        rdy = 0;
        drive(1, 0, 0, 9, 9, 0, 0, 9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_valid", 32'(out_valid), 32'd1);
            check("pause_res", out_res, 32'd30);
        end
        rdy = 1; idle(); tick();
        check("pause_popped", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ot, op;
            logic [31:0] a, b, im;
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 29) == 0);
            cdb_grant = ($urandom_range(0, 3) != 0);
            ot = 4'($urandom_range(0, 7));
            op = (ot == 2) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 10));
            a  = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 8)) - 32'd4;
            b  = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 8)) - 32'd4;
            im = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 40)) - 32'd20;
            drive(($urandom_range(0, 2) != 0) && !model_af(), ot, op, a, b, im,
                  $urandom(), 4'($urandom_range(1, 15)));
            tick();
        end
        rdy = 1; flush = 0; cdb_grant = 1; idle();
        repeat (8) tick();
        check("final_drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_cdb_unit.md
Name: alu_cdb_unit

Overview:
- Execution unit on the consumer side of the ALU reservation station.
- Captures one issued operation per cycle (RS issue strobe plus operand bundle) and computes the integer or branch result.
- Queues results in a small FIFO and drives them onto the ALU result broadcast bus (the RS/ROB update port: valid, ROB tag, value) under a CDB grant handshake.
- Resolves conditional branches and JALR targets for the ROB.

Parameters:
- ROB_SZ_LOG, 3, ROB tag width is ROB_SZ_LOG+1 bits; tag 0 is reserved as "no tag".
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global pause; when low, all state holds
- flush  in  1  misprediction flush; clears all in-flight work
- in_valid  in  1  issue strobe from RS
- in_Vj  in  32  operand 1
- in_Vk  in  32  operand 2
- in_imm  in  32  immediate
- in_pc  in  32  instruction PC
- in_opcode  in  4  operation select
- in_optype  in  4  format select
- in_dest  in  ROB_SZ_LOG+1  destination ROB tag
- cdb_grant  in  1  bus granted this cycle
- almost_full  out  1  upstream must stop issuing
- out_valid  out  1  result available on bus
- out_dest  out  ROB_SZ_LOG+1  result tag
- out_res  out  32  result value
- out_br_flg  out  1  entry is a conditional branch or JALR
- out_br_taken  out  1  branch taken (always 1 for JALR)
- out_br_target  out  32  resolved target

Behaviour:
- Encoding, optype: 0 R, 1 I-arith, 2 BRANCH, 3 LUI, 4 AUIPC, 5 JAL, 6 JALR. Other optype values produce res 0 with br_flg 0.
- Encoding, opcode (R/I): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- Encoding, opcode (BRANCH): 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU.
- Operand 2 is in_Vk for R and in_imm for I. Shift amount is the low 5 bits of operand 2. SUB with optype I is treated as ADD.
- LUI: res = imm.
- AUIPC: res = pc+imm.
- JAL: res = pc+4, br_flg 0.
- JALR: res = pc+4, br_flg 1, taken 1, target = (Vj+imm) & ~1.
- BRANCH: res 0, br_flg 1, taken per compare, target = pc+imm. All adds wrap modulo 2^32.
- Pipeline, stage S1: edge E captures the in_* bundle when in_valid (S1 valid bit set), else clears S1 valid.
- Pipeline, compute: combinational from S1.
- Pipeline, FIFO push: at edge E+1 the result is pushed if S1 valid.
- Pipeline, latency: out_valid is high in the cycle after E+1 at the earliest (FIFO empty case).
- FIFO: out_* reflect the head entry combinationally; out_valid = (count != 0).
- Pop at an edge where out_valid && cdb_grant. Simultaneous push and pop is legal, count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- almost_full = count + S1valid >= FIFO_DEPTH-1, so one more issue still fits.
- Push while full is a protocol violation: entry dropped, simulation assertion fires.
- Reset (rst) and flush share one priority order: rst > ~rdy (hold) > flush > normal.
- Reset and flush effects: S1 valid = 0, FIFO pointers and count = 0, and in_valid in the same cycle is ignored.
- Output values after reset: out_valid 0 and almost_full 0. Other outputs show the empty-FIFO default of all zeros.
- rdy low: no capture, no push, no pop; outputs stable.

Test Plan:
- Directed ADD chain: issue ADD Vj=5 Vk=7 dest=3 at edge 1, cdb_grant held 1 -> out_valid high after edge 2 with dest 3 and res 12; popped at edge 3.
- ALU edge cases: SUB 0-1 gives 0xFFFFFFFF; SRA 0x80000000 by Vk=0x21 (shift 1) gives 0xC0000000; SLTU 1<0xFFFFFFFF gives 1; SLT gives 0. Each result appears one cycle after capture.
- Branch/JALR resolution: BLT pc=0x100 imm=-8 with Vj=-1, Vk=0 -> br_flg 1, taken 1, target 0xF8. JALR pc=0x40 Vj=0x1001 imm=2 -> res 0x44, target 0x1002.
- Backpressure: cdb_grant 0 while issuing every cycle -> almost_full rises once count+S1 reaches 3; issue stops; after grant, results drain in issue order with no drop and no duplicate.
- Flush mid-stream: flush with S1 valid and 2 FIFO entries, plus in_valid the same cycle -> next cycle out_valid 0 and almost_full 0; a fresh issue afterward completes normally.
- Pause: rdy low for 3 cycles with a result at the head and grant 1 -> head held and not popped; popped on the first edge with rdy high.
